// File: rtl/hv_stream_deser.sv
// hv_stream_deser: reassembles BEAT_W-bit stream beats (beat 0 = LSBs) into a DIM+1-bit
// hypervector behind an assembly register and an output register. HV_DESER_COUNT_EN adds hv_count.
module hv_stream_deser #(
    parameter int DIM    = 1023,
    parameter int BEAT_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_v,
    input  logic [BEAT_W-1:0] src_d,
    input  logic              src_last,
    output logic              src_ready,
    output logic              hv_v,
    output logic [DIM:0]      hv_d,
    input  logic              hv_ready,
    input  logic              err_clr,
    output logic              err_len,
    output logic [31:0]       hv_count
);
    localparam int NBEAT = (DIM + 1) / BEAT_W;
    localparam int IW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBEAT - 1);

    typedef enum logic [0:0] {
        S_FILL,
        S_HOLD
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [DIM:0]  asm_q;
    logic [DIM:0]  asm_wr;
    logic          beat_acc;
    logic          at_last_slot;
    logic          complete;
    logic          frame_err;
    logic          out_take;
    logic          out_free;

    assign src_ready    = (state == S_FILL);
    assign beat_acc     = src_v && src_ready;
    assign at_last_slot = (idx == IDX_LAST);
    assign complete     = beat_acc && (src_last || at_last_slot);
    // Framing is wrong when src_last and the final slot disagree (early last or missing last).
    assign frame_err    = complete && (src_last != at_last_slot);
    assign out_take     = hv_v && hv_ready;
    assign out_free     = !hv_v || hv_ready;

    always_comb begin
        asm_wr = asm_q;
        for (int unsigned i = 0; i < NBEAT; i++) begin
            if (idx == IW'(i)) begin
                asm_wr[i*BEAT_W +: BEAT_W] = src_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FILL;
            idx     <= '0;
            asm_q   <= '0;
            hv_v    <= 1'b0;
            hv_d    <= '0;
            err_len <= 1'b0;
        end else begin
            // A reload below overrides this drop, keeping hv_v high across back-to-back vectors.
            if (out_take) begin
                hv_v <= 1'b0;
            end

            if (frame_err) begin
                err_len <= 1'b1;
            end else if (err_clr) begin
                err_len <= 1'b0;
            end

            case (state)
                S_FILL: begin
                    if (beat_acc) begin
                        if (complete) begin
                            idx <= '0;
                            if (out_free) begin
                                hv_d  <= asm_wr;
                                hv_v  <= 1'b1;
                                asm_q <= '0;
                            end else begin
                                asm_q <= asm_wr;
                                state <= S_HOLD;
                            end
                        end else begin
                            asm_q <= asm_wr;
                            idx   <= idx + IW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (out_take) begin
                        hv_d  <= asm_q;
                        hv_v  <= 1'b1;
                        asm_q <= '0;
                        state <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

`ifdef HV_DESER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hv_count <= '0;
        end else if (out_take) begin
            hv_count <= hv_count + 32'd1;
        end
    end
`else
    assign hv_count = '0;
`endif

endmodule

// File: tb/tb_hv_stream_deser.sv
// Scoreboard bench for hv_stream_deser: the driver pushes expected vectors built from the
// accepted beats; a negedge monitor compares them against hv_d whenever hv_v is high.
module tb_hv_stream_deser;
    localparam int DIM   = 1023;
    localparam int BW    = 256;
    localparam int VW    = DIM + 1;
    localparam int NBEAT = VW / BW;
`ifdef HV_DESER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          src_v = 1'b0;
    logic [BW-1:0] src_d = '0;
    logic          src_last = 1'b0;
    logic          src_ready;
    logic          hv_v;
    logic [DIM:0]  hv_d;
    logic          hv_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic          err_len;
    logic [31:0]   hv_count;

    int            checks = 0;
    int            failures = 0;
    logic [VW-1:0] exp_q[$];
    logic [BW-1:0] beats[$];
    bit            err_exp = 1'b0;
    int unsigned   sent_cnt = 0;
    int unsigned   hv_cycles = 0;
    int unsigned   sr_low = 0;
    int            ready_mode = 1;

    hv_stream_deser #(.DIM(DIM), .BEAT_W(BW)) dut (
        .clk(clk), .rst(rst), .src_v(src_v), .src_d(src_d), .src_last(src_last),
        .src_ready(src_ready), .hv_v(hv_v), .hv_d(hv_d), .hv_ready(hv_ready),
        .err_clr(err_clr), .err_len(err_len), .hv_count(hv_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       hv_ready = 1'b0;
            1:       hv_ready = 1'b1;
            default: hv_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int k = 0; k < NBEAT; k++) begin
                if (act[k*BW +: BW] !== exp[k*BW +: BW]) begin
                    $display("FAIL %s: beat %0d got %h expected %h", name, k,
                             act[k*BW +: BW], exp[k*BW +: BW]);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (hv_v) begin
                hv_cycles++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL hv_unexpected: got hv_v=1 expected no pending vector");
                end else begin
                    chk_vec("hv_d", hv_d, exp_q[0]);
                    if (hv_ready) void'(exp_q.pop_front());
                end
            end
            if (!src_ready) sr_low++;
        end
    end

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a vector is the accepted beats laid out LSB-first, zero above the last one.
    task automatic model_accept(input logic [BW-1:0] d, input logic last);
        logic [VW-1:0] v;
        beats.push_back(d);
        if (last || beats.size() == NBEAT) begin
            v = '0;
            foreach (beats[i]) v[i*BW +: BW] = beats[i];
            exp_q.push_back(v);
            if (beats.size() != NBEAT || !last) err_exp = 1'b1;
            beats.delete();
            sent_cnt++;
        end
    endtask

    task automatic send_beat(input logic [BW-1:0] d, input logic last, input int unsigned gap);
        bit acc;
        int waited;
        repeat (gap) begin
            src_v    = 1'b0;
            src_d    = rand_beat();
            src_last = 1'($urandom_range(0, 1));
            tick();
        end
        src_v    = 1'b1;
        src_d    = d;
        src_last = last;
        acc      = 1'b0;
        waited   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = src_ready;
            tick();
            if (!acc) begin
                waited++;
                if (waited > 200) begin
                    chk("src_ready_timeout", 32'(waited), 0);
                    break;
                end
            end
        end
        src_v    = 1'b0;
        src_last = 1'b0;
        if (acc) model_accept(d, last);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        src_v = 1'b0;
        beats.delete();
        tick();
        tick();
        rst      = 1'b0;
        err_exp  = 1'b0;
        sent_cnt = 0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hv_v) && n < 300) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] a[4];
        logic [BW-1:0] aa;
        logic [BW-1:0] bb;
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        int unsigned   hb;
        int unsigned   sb;
        int            kind;
        int            len;
        bit            endlast;

        ready_mode = 1;
        do_reset();
        @(negedge clk);
        chk("rst_hv_v", hv_v, 0);
        chk("rst_src_ready", src_ready, 1);
        chk("rst_err_len", err_len, 0);
        chk("rst_hv_count", hv_count, 0);
        chk_vec("rst_hv_d", hv_d, '0);
        tick();

        // Single vector, one-cycle latency
        for (int i = 0; i < 4; i++) a[i] = rand_beat();
        for (int i = 0; i < 4; i++) send_beat(a[i], i == 3, 0);
        @(negedge clk);
        chk("lat_hv_v", hv_v, 1);
        chk_vec("lat_hv_d", hv_d, {a[3], a[2], a[1], a[0]});
        chk("lat_err_len", err_len, 0);
        tick();
        tick();

        // Back-to-back vectors
        hb = hv_cycles;
        sb = sr_low;
        for (int i = 0; i < 8; i++) send_beat(rand_beat(), (i % 4) == 3, 0);
        repeat (3) tick();
        chk("b2b_hv_cycles", hv_cycles - hb, 2);
        chk("b2b_src_ready_low", sr_low - sb, 0);
        chk("count_3", hv_count, COUNT_EN ? 32'd3 : 32'd0);

        // Output blocked: second vector parks in HOLD
        ready_mode = 0;
        tick();
        for (int i = 0; i < 4; i++) a[i] = rand_beat();
        v1 = {a[3], a[2], a[1], a[0]};
        for (int i = 0; i < 4; i++) send_beat(a[i], i == 3, 0);
        for (int i = 0; i < 4; i++) a[i] = rand_beat();
        v2 = {a[3], a[2], a[1], a[0]};
        for (int i = 0; i < 4; i++) send_beat(a[i], i == 3, 0);
        @(negedge clk);
        chk("hold_src_ready", src_ready, 0);
        chk("hold_hv_v", hv_v, 1);
        chk_vec("hold_hv_d", hv_d, v1);
        tick();
        @(negedge clk);
        chk("hold_src_ready_2", src_ready, 0);
        tick();
        ready_mode = 1;
        tick();
        @(negedge clk);
        chk_vec("hold_exit_hv_d", hv_d, v2);
        chk("hold_exit_hv_v", hv_v, 1);
        chk("hold_exit_src_ready", src_ready, 1);
        tick();
        tick();

        // Early src_last, sticky error, clear, and set-beats-clear
        aa = {32{8'hAA}};
        bb = {32{8'hBB}};
        send_beat(aa, 1'b0, 0);
        send_beat(bb, 1'b1, 0);
        @(negedge clk);
        chk("early_hv_v", hv_v, 1);
        chk_vec("early_hv_d", hv_d, {512'b0, bb, aa});
        chk("early_err_len", err_len, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("early_err_sticky", err_len, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        chk("err_clr", err_len, 0);
        tick();
        send_beat(aa, 1'b0, 0);
        err_clr = 1'b1;
        send_beat(bb, 1'b1, 0);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_set_wins", err_len, 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_exp = 1'b0;

        // Missing src_last: emitted anyway, framing re-aligns
        for (int i = 0; i < 4; i++) a[i] = rand_beat();
        for (int i = 0; i < 4; i++) send_beat(a[i], 1'b0, 0);
        @(negedge clk);
        chk("miss_err_len", err_len, 1);
        chk_vec("miss_hv_d", hv_d, {a[3], a[2], a[1], a[0]});
        tick();
        for (int i = 0; i < 4; i++) send_beat(rand_beat(), i == 3, 0);
        wait_drain("miss_drain");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        err_exp = 1'b0;

        // Reset with a pending output and a partial assembly
        ready_mode = 0;
        tick();
        for (int i = 0; i < 4; i++) send_beat(rand_beat(), i == 3, 0);
        send_beat(rand_beat(), 1'b0, 0);
        send_beat(rand_beat(), 1'b0, 0);
        ready_mode = 1;
        do_reset();
        @(negedge clk);
        chk("rst_mid_hv_v", hv_v, 0);
        tick();
        for (int i = 0; i < 4; i++) a[i] = rand_beat();
        for (int i = 0; i < 4; i++) send_beat(a[i], i == 3, 0);
        @(negedge clk);
        chk_vec("rst_mid_hv_d", hv_d, {a[3], a[2], a[1], a[0]});
        tick();
        tick();
        chk("rst_mid_count", hv_count, COUNT_EN ? 32'd1 : 32'd0);

        // Randomized framing, gaps and back-pressure
        do_reset();
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            if (kind < 2) begin
                len     = $urandom_range(1, NBEAT - 1);
                endlast = 1'b1;
            end else if (kind == 2) begin
                len     = NBEAT;
                endlast = 1'b0;
            end else begin
                len     = NBEAT;
                endlast = 1'b1;
            end
            for (int b = 0; b < len; b++) begin
                send_beat(rand_beat(), (b == len - 1) && endlast,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
        end
        ready_mode = 1;
        wait_drain("rand_drain");
        @(negedge clk);
        chk("rand_err_len", err_len, 32'(err_exp));
        chk("rand_count", hv_count, COUNT_EN ? sent_cnt : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
